// File: rtl/uart_tx_scheduler.sv
// Two-requester frame scheduler feeding a UART TX FIFO.
// Frames: header, payload hi, payload lo, XOR checksum.
module uart_tx_scheduler #(
  parameter logic [3:0] HDR_TAG    = 4'hA,
  parameter int         GAP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ack,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ack,
  input  logic        tx_full,
  output logic [7:0]  w_data,
  output logic        wr_uart,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PLH,
    S_PLL,
    S_CHK,
    S_GAP
  } state_t;

  localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES);

  state_t      r_state;
  logic [15:0] r_data;
  logic        r_src;
  logic        r_last;
  logic [15:0] r_gap;

  state_t      w_nstate;
  logic [15:0] w_ndata;
  logic        w_nsrc;
  logic        w_nlast;
  logic [15:0] w_ngap;
  logic [7:0]  w_nwdata;
  logic        w_nwr;
  logic        w_nack0;
  logic        w_nack1;
  logic [15:0] w_ncnt;

  logic [7:0]  w_hdr;
  logic [7:0]  w_chk;
  logic [7:0]  w_byte;
  state_t      w_adv;
  logic        w_pick1;

  assign w_hdr = {HDR_TAG, 3'b000, r_src};
  assign w_chk = w_hdr ^ r_data[15:8] ^ r_data[7:0];

  // r_last=1 means requester 1 was granted last, so 0 wins a tie
  assign w_pick1 = req1_valid & (~req0_valid | ~r_last);

  always_comb begin
    w_byte = w_hdr;
    w_adv  = S_IDLE;
    unique case (r_state)
      S_HDR: begin
        w_byte = w_hdr;
        w_adv  = S_PLH;
      end
      S_PLH: begin
        w_byte = r_data[15:8];
        w_adv  = S_PLL;
      end
      S_PLL: begin
        w_byte = r_data[7:0];
        w_adv  = S_CHK;
      end
      S_CHK: begin
        w_byte = w_chk;
        w_adv  = (GAP_LD == 16'd0) ? S_IDLE : S_GAP;
      end
      default: begin
        w_byte = w_hdr;
        w_adv  = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    w_ndata  = r_data;
    w_nsrc   = r_src;
    w_nlast  = r_last;
    w_ngap   = r_gap;
    w_nwdata = w_data;
    w_nwr    = 1'b0;
    w_nack0  = 1'b0;
    w_nack1  = 1'b0;
    w_ncnt   = frame_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_nstate = S_HDR;
          w_nsrc   = w_pick1;
          w_nlast  = w_pick1;
          w_ndata  = w_pick1 ? req1_data : req0_data;
          w_nack0  = ~w_pick1;
          w_nack1  = w_pick1;
        end
      end
      S_HDR, S_PLH, S_PLL, S_CHK: begin
        // wr_uart gate absorbs the FIFO's one-cycle full-flag lag
        if (!tx_full && !wr_uart) begin
          w_nwr    = 1'b1;
          w_nwdata = w_byte;
          w_nstate = w_adv;
          if (r_state == S_CHK) begin
            w_ncnt = frame_cnt + 16'd1;
            w_ngap = GAP_LD;
          end
        end
      end
      S_GAP: begin
        if (r_gap != 16'd0) w_ngap = r_gap - 16'd1;
        if (r_gap <= 16'd1) w_nstate = S_IDLE;
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_data    <= 16'd0;
      r_src     <= 1'b0;
      r_last    <= 1'b1;
      r_gap     <= 16'd0;
      w_data    <= 8'd0;
      wr_uart   <= 1'b0;
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      r_state   <= w_nstate;
      r_data    <= w_ndata;
      r_src     <= w_nsrc;
      r_last    <= w_nlast;
      r_gap     <= w_ngap;
      w_data    <= w_nwdata;
      wr_uart   <= w_nwr;
      req0_ack  <= w_nack0;
      req1_ack  <= w_nack1;
      busy      <= (w_nstate != S_IDLE);
      frame_cnt <= w_ncnt;
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter HDR_TAG, default 4'hA, upper nibble of every frame header byte.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 16, idle cycles enforced between frames (0 legal).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req0_valid  input  1  requester 0 has a payload; held until req0_ack.
REQ-007 req0_data  input  16  requester 0 payload; stable while req0_valid.
REQ-008 req0_ack  output  1  one-cycle pulse; req0_data captured.
REQ-009 req1_valid  input  1  requester 1 has a payload; held until req1_ack.
REQ-010 req1_data  input  16  requester 1 payload; stable while req1_valid.
REQ-011 req1_ack  output  1  one-cycle pulse; req1_data captured.
REQ-012 tx_full  input  1  UART TX FIFO full flag.
REQ-013 w_data  output  8  byte to UART TX FIFO.
REQ-014 wr_uart  output  1  one-cycle write strobe to UART TX FIFO.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 frame_cnt  output  16  count of completed frames, wraps 16'hFFFF -> 0.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 Frame SHALL be 4 bytes in order: HDR = {HDR_TAG, 3'b000, src_id}, data[15:8], data[7:0], CHK = XOR of previous three bytes.
REQ-019 FSM states SHALL be IDLE, HDR, PLH, PLL, CHK, GAP.
REQ-020 IDLE: if any reqX_valid, next edge latches selected payload and src_id, sets reqX_ack=1 for exactly one cycle, moves to HDR; otherwise stays.
REQ-021 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; one valid -> grant it; reset state gives requester 0 priority.
REQ-022 At most one ack SHALL be high in any cycle; no ack outside the IDLE->HDR transition.
REQ-023 Byte states (HDR, PLH, PLL, CHK): if tx_full=0 and wr_uart=0 this cycle, next edge drives w_data=byte, wr_uart=1, advances state; else wr_uart=0, hold state.
REQ-024 wr_uart SHALL never be high in two consecutive cycles (covers one-cycle tx_full update latency).
REQ-025 w_data SHALL hold its last value when wr_uart=0.
REQ-026 On the CHK byte write, frame_cnt SHALL increment and the state SHALL go to GAP loaded with GAP_CYCLES, or to IDLE directly if GAP_CYCLES=0.
REQ-027 GAP SHALL count down one per cycle and enter IDLE when the count reaches 0; requests are not sampled in GAP.
REQ-028 tx_full held high SHALL stall indefinitely with no byte lost, duplicated or reordered.
REQ-029 Requests asserted while busy SHALL wait; their payload SHALL not be sampled before their ack.
REQ-030 Minimum frame latency from grant edge to CHK write SHALL be 7 cycles (4 writes, 3 mandatory gaps) with tx_full=0.

Reset
REQ-031 rst SHALL force, asynchronously: state=IDLE, w_data=0, wr_uart=0, req0_ack=0, req1_ack=0, busy=0, frame_cnt=0, gap counter=0, round-robin pointer to requester-0 priority.
REQ-032 Reset mid-frame SHALL abandon the frame; no further bytes of it are written after reset release.

Verification
REQ-033 req0_valid, data 16'h1234, tx_full=0 -> one req0_ack pulse; writes A0,12,34,86 on alternate cycles; frame_cnt=1; busy low GAP_CYCLES cycles after CHK write.
REQ-034 req0 and req1 (16'hBEEF) asserted together from reset -> req0 frame A0,12,34,86 first, then after gap req1 frame A1,BE,EF,F0; then both again -> req0 served first (alternation holds).
REQ-035 tx_full forced high for 20 cycles after HDR write -> no wr_uart during stall; PLH then resumes; frame byte order intact.
REQ-036 rst pulsed after PLH write -> all outputs zero immediately; no PLL/CHK writes after release; next request produces a full fresh frame.
REQ-037 GAP_CYCLES=0, req0 held continuously with new data each ack -> back-to-back frames, wr_uart never high two consecutive cycles, frame_cnt wraps FFFF->0 after 65536 frames.
